// File: rtl/sp_update_sequencer_if.sv
// Control bundle between the state-update sequencer and the subtractor/systolic datapath.
interface sp_update_sequencer_if;
  localparam int unsigned N_SUB = 6;

  logic [N_SUB-1:0] sub_finish;
  logic             sub_valid;
  logic             mtx_latch;
  logic             sa_load_en;
  logic             sa_enb_1;
  logic             sa_enb_2_6;
  logic             sa_enb_7_12;
  logic             xkk_capture;

  modport master (
    input  sub_finish,
    output sub_valid, mtx_latch, sa_load_en,
    output sa_enb_1, sa_enb_2_6, sa_enb_7_12, xkk_capture
  );

  modport slave (
    output sub_finish,
    input  sub_valid, mtx_latch, sa_load_en,
    input  sa_enb_1, sa_enb_2_6, sa_enb_7_12, xkk_capture
  );
endinterface

// File: rtl/sp_update_sequencer.sv
// Sequencer for X_kk = X_kk1 + K_k*(Z_k - H*X_kk1): innovation subtract, latch, array load,
// latency count, capture. Abortable, with a timeout on the subtractor wait.
module sp_update_sequencer #(
  parameter int unsigned SA_LATENCY  = 12,
  parameter int unsigned SUB_TIMEOUT = 64,
  parameter int unsigned ACTIVE_COLS = 6,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  sp_update_sequencer_if.master    dp,
  output logic                     busy,
  output logic                     sp_done,
  output logic                     timeout_err,
  output logic [CNT_W-1:0]         done_cnt
);

  localparam int unsigned TMR_W     = 8;
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(SUB_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LAT_LAST  = TMR_W'(SA_LATENCY - 1);
  localparam logic ENB_1     = 1'(ACTIVE_COLS >= 1);
  localparam logic ENB_2_6   = 1'(ACTIVE_COLS >= 2);
  localparam logic ENB_7_12  = 1'(ACTIVE_COLS >= 7);

  typedef enum logic [2:0] {
    S_IDLE, S_SUB, S_LATCH, S_LOAD, S_COMP, S_CAPT, S_DONE
  } state_t;

  state_t           state, state_n;
  logic [TMR_W-1:0] wait_cnt;
  logic [TMR_W-1:0] lat_cnt;
  logic             sub_timeout;
  logic             array_on;

  // Next-state decode; abort overrides every transition out of a busy state.
  always_comb begin
    state_n     = state;
    sub_timeout = 1'b0;
    case (state)
      S_IDLE:  if (start) state_n = S_SUB;
      S_SUB: begin
        if (&dp.sub_finish) begin
          state_n = S_LATCH;
        end else if (wait_cnt == WAIT_LAST) begin
          state_n     = S_IDLE;
          sub_timeout = 1'b1;
        end
      end
      S_LATCH: state_n = S_LOAD;
      S_LOAD:  state_n = S_COMP;
      S_COMP:  if (lat_cnt == LAT_LAST) state_n = S_CAPT;
      S_CAPT:  state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) begin
      state_n     = S_IDLE;
      sub_timeout = 1'b0;
    end
    array_on = (state_n == S_LOAD) || (state_n == S_COMP);
  end

  // State, counters and Moore outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      lat_cnt        <= '0;
      timeout_err    <= 1'b0;
      done_cnt       <= '0;
      busy           <= 1'b0;
      sp_done        <= 1'b0;
      dp.sub_valid   <= 1'b0;
      dp.mtx_latch   <= 1'b0;
      dp.sa_load_en  <= 1'b0;
      dp.sa_enb_1    <= 1'b0;
      dp.sa_enb_2_6  <= 1'b0;
      dp.sa_enb_7_12 <= 1'b0;
      dp.xkk_capture <= 1'b0;
    end else begin
      state <= state_n;

      if (state == S_IDLE)      wait_cnt <= '0;
      else if (state == S_SUB)  wait_cnt <= wait_cnt + TMR_W'(1);

      // First COMP cycle sees lat_cnt == 0, so COMP spans SA_LATENCY cycles.
      if (state == S_LOAD)      lat_cnt <= '0;
      else if (state == S_COMP) lat_cnt <= lat_cnt + TMR_W'(1);

      if ((state == S_IDLE) && start) timeout_err <= 1'b0;
      else if (sub_timeout)           timeout_err <= 1'b1;

      if ((state == S_DONE) && !abort) done_cnt <= done_cnt + CNT_W'(1);

      busy           <= (state_n != S_IDLE);
      sp_done        <= (state_n == S_DONE);
      dp.sub_valid   <= (state_n == S_SUB);
      dp.mtx_latch   <= (state_n == S_LATCH);
      dp.sa_load_en  <= (state_n == S_LOAD);
      dp.sa_enb_1    <= array_on & ENB_1;
      dp.sa_enb_2_6  <= array_on & ENB_2_6;
      dp.sa_enb_7_12 <= array_on & ENB_7_12;
      dp.xkk_capture <= (state_n == S_CAPT);
    end
  end

endmodule

// File: tb/tb_sp_update_sequencer.sv
// Directed bench for sp_update_sequencer: a default instance and a CNT_W=4/ACTIVE_COLS=12 instance
// share one stimulus stream.
module tb_sp_update_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [5:0] sub_finish;
  logic       busy_a, done_a, terr_a, busy_b, done_b, terr_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int total = 0;
  int bad   = 0;
  int exp_done = 0;
  int pulses;

  sp_update_sequencer_if if_a ();
  sp_update_sequencer_if if_b ();
  assign if_a.sub_finish = sub_finish;
  assign if_b.sub_finish = sub_finish;

  sp_update_sequencer dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dp(if_a.master),
    .busy(busy_a), .sp_done(done_a), .timeout_err(terr_a), .done_cnt(cnt_a)
  );

  sp_update_sequencer #(.SA_LATENCY(12), .SUB_TIMEOUT(64), .ACTIVE_COLS(12), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dp(if_b.master),
    .busy(busy_b), .sp_done(done_b), .timeout_err(terr_b), .done_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  // {sub_valid, mtx_latch, sa_load_en, enb_1, enb_2_6, enb_7_12, xkk_capture, busy, sp_done}
  localparam logic [8:0] V_SUB   = 9'b100_000_010;
  localparam logic [8:0] V_LATCH = 9'b010_000_010;
  localparam logic [8:0] V_LOAD  = 9'b001_110_010;
  localparam logic [8:0] V_COMP  = 9'b000_110_010;
  localparam logic [8:0] V_CAPT  = 9'b000_000_110;
  localparam logic [8:0] V_DONE  = 9'b000_000_011;
  localparam logic [8:0] V_COL12 = 9'b000_001_000;

  wire [8:0] obs_a = {if_a.sub_valid, if_a.mtx_latch, if_a.sa_load_en, if_a.sa_enb_1,
                      if_a.sa_enb_2_6, if_a.sa_enb_7_12, if_a.xkk_capture, busy_a, done_a};
  wire [8:0] obs_b = {if_b.sub_valid, if_b.mtx_latch, if_b.sa_load_en, if_b.sa_enb_1,
                      if_b.sa_enb_2_6, if_b.sa_enb_7_12, if_b.xkk_capture, busy_b, done_b};

  // Expected strobes at cycle c of a sequence whose LATCH falls on latch_c (SA_LATENCY=12).
  function automatic logic [8:0] exp_vec(input int c, input int latch_c, input logic cols12);
    logic [8:0] x;
    x = cols12 ? V_COL12 : 9'b0;
    if (c < 1 || c > latch_c + 15) return 9'b0;
    if (c < latch_c)               return V_SUB;
    if (c == latch_c)              return V_LATCH;
    if (c == latch_c + 1)          return V_LOAD | x;
    if (c <= latch_c + 13)         return V_COMP | x;
    if (c == latch_c + 14)         return V_CAPT;
    return V_DONE;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vecs(input int c, input logic [8:0] ea, input logic [8:0] eb);
    chk($sformatf("strobes_a c%0d", c), 32'(obs_a), 32'(ea));
    chk($sformatf("strobes_b c%0d", c), 32'(obs_b), 32'(eb));
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt_a"}, 32'(cnt_a), 32'(exp_done % 65536));
    chk({tag, "_cnt_b"}, 32'(cnt_b), 32'(exp_done % 16));
  endtask

  // One sequence from an IDLE cycle. mode 0: finish=3F; 1: staggered lanes; 2: 3F plus start
  // pulses while busy. abort_c>0 raises abort during that cycle.
  task automatic run_seq(input string tag, input int latch_c, input int mode,
                         input int ncyc, input int abort_c);
    logic [8:0] ea, eb;
    start      = 1'b1;
    sub_finish = (mode == 1) ? 6'h00 : 6'h3F;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      start = (mode == 2) && (c == 5 || c == 9 || c == 13);
      if (mode == 1)
        for (int i = 0; i < 6; i++) sub_finish[i] = (c >= 2 * i + 1);
      if (abort_c > 0 && c > abort_c) begin
        ea = 9'b0; eb = 9'b0;
      end else begin
        ea = exp_vec(c, latch_c, 1'b0);
        eb = exp_vec(c, latch_c, 1'b1);
      end
      chk_vecs(c, ea, eb);
      if (c == 1) chk({tag, "_terr_cleared"}, 32'(terr_a), 32'd0);
      abort = (abort_c > 0) && (c == abort_c);
    end
    abort = 1'b0;
    if (abort_c == 0) exp_done++;
    chk_cnt(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; sub_finish = 6'h00;
    tick(); tick();
    chk_vecs(0, 9'b0, 9'b0);
    chk_cnt("reset");
    chk("reset_terr", 32'({terr_a, terr_b}), 32'd0);
    rst = 1'b0;
    tick();

    // Nominal: sp_done at cycle 17.
    run_seq("nominal", 2, 0, 18, 0);

    // Staggered lane finish: LATCH at 12, sp_done at 27.
    run_seq("stagger", 12, 1, 28, 0);
    chk("stagger_terr", 32'(terr_a), 32'd0);

    // One lane never finishes: timeout after 64 SUB cycles.
    start = 1'b1; sub_finish = 6'h1F; pulses = 0;
    for (int c = 1; c <= 66; c++) begin
      tick();
      start = 1'b0;
      if (done_a) pulses++;
      chk_vecs(c, (c <= 64) ? V_SUB : 9'b0, (c <= 64) ? V_SUB : 9'b0);
      if (c == 64) chk("terr_before", 32'({terr_a, terr_b}), 32'd0);
      if (c == 65) chk("terr_set", 32'({terr_a, terr_b}), 32'b11);
    end
    chk("timeout_no_done", 32'(pulses), 32'd0);
    chk_cnt("timeout");
    chk("terr_sticky", 32'(terr_a), 32'd1);

    // Next start clears timeout_err at its cycle 1 and completes normally.
    run_seq("after_timeout", 2, 0, 18, 0);

    // Abort in COMP at cycle 8, then a normal run with ignored start pulses while busy.
    run_seq("abort", 2, 0, 20, 8);
    run_seq("busy_start", 2, 2, 18, 0);

    // start held from cycle 0 through cycle 35: two sequences, sp_done at 17 and 35.
    start = 1'b1; sub_finish = 6'h3F; pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start = (c <= 35);
      if (done_a) pulses++;
      chk_vecs(c, exp_vec(c, (c <= 18) ? 2 : 20, 1'b0), exp_vec(c, (c <= 18) ? 2 : 20, 1'b1));
    end
    chk("held_start_pulses", 32'(pulses), 32'd2);
    exp_done += 2;
    chk_cnt("held_start");

    // Synchronous reset in LOAD clears everything on the next cycle.
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick();
    chk_vecs(3, V_LOAD, V_LOAD | V_COL12);
    rst = 1'b1;
    tick();
    chk_vecs(4, 9'b0, 9'b0);
    exp_done = 0;
    chk_cnt("rst_load");
    rst = 1'b0;
    tick();

    // 17 back-to-back updates: CNT_W=4 instance wraps to 1.
    start = 1'b1; pulses = 0;
    for (int c = 1; c <= 306; c++) begin
      tick();
      start = (c <= 288);
      if (done_a) pulses++;
      chk_vecs(c, exp_vec((c - 1) % 18 + 1, 2, 1'b0), exp_vec((c - 1) % 18 + 1, 2, 1'b1));
    end
    chk("wrap_pulses", 32'(pulses), 32'd17);
    exp_done = 17;
    chk_cnt("wrap");
    chk("wrap_b_is_1", 32'(cnt_b), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sp_update_sequencer.md
Name: sp_update_sequencer

Overview:
- Control FSM for the state-update datapath X_kk = X_kk1 + K_k·(Z_k − H·X_kk1).
- Launches the six fp subtractors for the innovation and waits for all six finish flags. Then latches the padded 12x12 operand matrices, pulses the systolic array load, counts the array latency and captures X_kk.
- Replaces free-running sub valid and the combinational load gating with one explicit, abortable, timeout-protected sequence. Reports done and error status to the top-level Kalman scheduler.

Parameters:
- SA_LATENCY, 12, cycles from the load_en pulse to valid c_out column 0; legal range 1..255.
- SUB_TIMEOUT, 64, maximum cycles spent in SUB waiting for all sub_finish bits; legal range 2..255.
- ACTIVE_COLS, 6, number of active systolic columns; selects the enb_* configuration; legal range 1..12.
- CNT_W, 16, width of the completed-update counter.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one update; sampled only in IDLE.
- abort  in  1  cancel an in-flight update; ignored in IDLE.
- sub_finish  in  6  per-lane finish flags from the six innovation subtractors.
- sub_valid  out  1  valid to all six subtractors.
- mtx_latch  out  1  enables the K/Z−HX 12x12 padding registers.
- sa_load_en  out  1  systolic array load pulse.
- sa_enb_1  out  1  array column-1 enable.
- sa_enb_2_6  out  1  array column 2–6 enable.
- sa_enb_7_12  out  1  array column 7–12 enable.
- xkk_capture  out  1  enables the X_kk output register.
- busy  out  1  high in every state except IDLE.
- sp_done  out  1  one-cycle completion pulse (SP_DONE).
- timeout_err  out  1  sticky subtractor-timeout flag.
- done_cnt  out  CNT_W  number of completed updates.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- All outputs are registered (Moore) and decoded from the next state, so each output is valid in the cycle its state is occupied.
- Reset: state=IDLE, counters=0, every output=0. Reset has priority over abort and start, and forces IDLE from any state mid-operation.
- States: IDLE, SUB, LATCH, LOAD, COMP, CAPT, DONE. Cycle 0 is the edge that samples start=1 in IDLE.
- IDLE: start=1 → SUB, clears wait_cnt and clears timeout_err.
- SUB (from cycle 1): sub_valid=1. wait_cnt increments every cycle.
  - If &sub_finish=1 → LATCH.
  - Else, when wait_cnt==SUB_TIMEOUT-1 → IDLE and set timeout_err; no done, no capture.
  - If finish and timeout occur in the same cycle, finish wins.
- LATCH: mtx_latch=1 for exactly one cycle → LOAD.
- LOAD: sa_load_en=1 for exactly one cycle; lat_cnt=0 → COMP.
- COMP: lat_cnt increments; at lat_cnt==SA_LATENCY-1 → CAPT.
  - COMP therefore lasts SA_LATENCY cycles.
- CAPT: xkk_capture=1 for one cycle → DONE.
- DONE: sp_done=1 for one cycle; done_cnt += 1, wrapping modulo 2^CNT_W → IDLE.
  - A start held high re-triggers only after IDLE is re-entered, giving a minimum one-cycle gap between sequences.
- Nominal latency (finish in the first SUB cycle):
  - LATCH=cycle 2, LOAD=3, COMP=4..3+SA_LATENCY, CAPT=4+SA_LATENCY, sp_done=5+SA_LATENCY.
  - With defaults, sp_done is at cycle 17.
- Column enables:
  - Outputs are 0 outside LOAD and COMP.
  - In LOAD and COMP: sa_enb_1 = (ACTIVE_COLS≥1), sa_enb_2_6 = (ACTIVE_COLS≥2), sa_enb_7_12 = (ACTIVE_COLS≥7).
  - Defaults give 1, 1, 0.
- abort=1 in any non-IDLE state:
  - Next state is IDLE and all strobes drop the following cycle.
  - No sp_done, no done_cnt increment, timeout_err unchanged.
  - abort takes priority over every other transition, including DONE.
- timeout_err remains 1 until the next accepted start or rst.
- start while busy is ignored; there is no queuing.

Test Plan:
- Reset then start pulse, sub_finish=6'h3F from cycle 1 → mtx_latch at cycle 2, sa_load_en at cycle 3, enb=1,1,0 during cycles 3–15, xkk_capture at cycle 16, sp_done at cycle 17, done_cnt=1, busy cycles 1–17.
- Staggered finish: lanes go high at cycles 1, 3, 5, 7, 9, 11 and are held → LATCH at cycle 12, sp_done at cycle 27, no timeout.
- sub_finish=6'h1F permanently, SUB_TIMEOUT=64 → busy cycles 1–64, back in IDLE at cycle 65 with timeout_err=1 and no sp_done. A following start clears timeout_err at its cycle 1.
- abort asserted during COMP at cycle 8 → IDLE at cycle 9, no xkk_capture, no sp_done, done_cnt unchanged. Next start completes normally.
- start held high for 40 cycles with immediate finish → exactly two sp_done pulses (cycles 17 and 35), done_cnt=2. start pulses during busy have no effect.
- rst=1 asserted in LOAD → all outputs 0 on the next cycle. CNT_W=4 with 17 back-to-back updates → done_cnt wraps to 1. ACTIVE_COLS=12 → sa_enb_7_12=1 during COMP.
